// File: rtl/mac_seq_ctrl.sv
// Control sequencer for the shift-and-add multiply-accumulate datapath: load, WIDTH shift/add steps, write-back.
// Optional MAC_OVF_DETECT_EN adds acc_carry input and a sticky acc_ovf flag.
module mac_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             acc_clr,
  input  logic             mplr_lsb,
  output logic             ld_operands,
  output logic             ld_acc_zero,
  output logic             add_en,
  output logic             shift_en,
  output logic             acc_wr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef MAC_OVF_DETECT_EN
  ,
  input  logic             acc_carry,
  output logic             acc_ovf
`endif
);

  // state  | meaning
  // IDLE   | waiting for start / acc_clr
  // CLRACC | clearing accumulator, optional pending start
  // LOAD   | loading operands, clearing partial product
  // CALC   | one shift/conditional-add per cycle, count = bit index
  // ACCUM  | adding product into accumulator
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE, CLRACC, LOAD, CALC, ACCUM, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;
  logic   start_pend;

  // Output flags are registered alongside the state they belong to.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state       <= IDLE;
      count       <= '0;
      start_pend  <= 1'b0;
      ld_operands <= 1'b0;
      ld_acc_zero <= 1'b0;
      shift_en    <= 1'b0;
      acc_wr      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ld_operands <= 1'b0;
      ld_acc_zero <= 1'b0;
      shift_en    <= 1'b0;
      acc_wr      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (acc_clr) begin
            state       <= CLRACC;
            start_pend  <= start;
            ld_acc_zero <= 1'b1;
          end else if (start) begin
            state       <= LOAD;
            ld_operands <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CLRACC: begin
          start_pend <= 1'b0;
          if (start_pend) begin
            state       <= LOAD;
            ld_operands <= 1'b1;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          state    <= CALC;
          count    <= '0;
          shift_en <= 1'b1;
          busy     <= 1'b1;
        end
        CALC: begin
          busy <= 1'b1;
          if (count == LAST) begin
            state  <= ACCUM;
            count  <= '0;
            acc_wr <= 1'b1;
          end else begin
            count    <= count + 1'b1;
            shift_en <= 1'b1;
          end
        end
        ACCUM: begin
          state <= DONE;
          count <= '0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // shift_en is high exactly in CALC, so this gates the add to CALC only.
  assign add_en = shift_en & mplr_lsb;

`ifdef MAC_OVF_DETECT_EN
  always_ff @(posedge CLK) begin
    if (CLR || ld_acc_zero) begin
      acc_ovf <= 1'b0;
    end else if (acc_wr && acc_carry) begin
      acc_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl (WIDTH=8); exercises the overflow flag when MAC_OVF_DETECT_EN is defined.
module tb_mac_seq_ctrl;

  logic       CLK = 1'b0;
  logic       CLR, start, acc_clr, mplr_lsb;
  logic       ld_operands, ld_acc_zero, add_en, shift_en, acc_wr, busy, done;
  logic [2:0] count;
`ifdef MAC_OVF_DETECT_EN
  logic       acc_carry, acc_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int done_seen;

  mac_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .acc_clr(acc_clr), .mplr_lsb(mplr_lsb),
    .ld_operands(ld_operands), .ld_acc_zero(ld_acc_zero), .add_en(add_en),
    .shift_en(shift_en), .acc_wr(acc_wr), .busy(busy), .done(done), .count(count)
`ifdef MAC_OVF_DETECT_EN
    , .acc_carry(acc_carry), .acc_ovf(acc_ovf)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Packed view: {ld_operands, ld_acc_zero, add_en, shift_en, acc_wr, busy, done, count}
  function automatic logic [9:0] ev(input logic lo, input logic lz, input logic ad, input logic sh,
                                    input logic wr, input logic bz, input logic dn, input logic [2:0] c);
    return {lo, lz, ad, sh, wr, bz, dn, c};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {ld_operands, ld_acc_zero, add_en, shift_en, acc_wr, busy, done, count};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full operation from a start pulse; bits[i] is mplr_lsb in CALC step i.
  task automatic run_op(input string tag, input logic [7:0] bits);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " load"}, ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    for (int i = 0; i < 8; i++) begin
      tick();
      mplr_lsb = bits[i];
      #1;
      chk($sformatf("%s calc%0d", tag, i), ev(0, 0, bits[i], 1, 0, 1, 0, 3'(i)));
    end
    tick();
    mplr_lsb = 1'b1;
    #1;
    chk({tag, " accum"}, ev(0, 0, 0, 0, 1, 1, 0, 3'd0));
    tick();
    chk({tag, " done"}, ev(0, 0, 0, 0, 0, 0, 1, 3'd0));
    tick();
    chk({tag, " idle"}, ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
    mplr_lsb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLR = 1'b1; start = 1'b0; acc_clr = 1'b0; mplr_lsb = 1'b0;
`ifdef MAC_OVF_DETECT_EN
    acc_carry = 1'b0;
`endif
    tick();
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("reset idle %0d", i), ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
    end

    // add_en pattern 1,0,1,1,0,0,0,1
    run_op("mac1", 8'b1000_1101);

    // Clear alone
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("clr lz", ev(0, 1, 0, 0, 0, 0, 0, 3'd0));
    tick();
    chk("clr idle1", ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
    tick();
    chk("clr idle2", ev(0, 0, 0, 0, 0, 0, 0, 3'd0));

    // Clear and start together: clear then multiply
    acc_clr = 1'b1;
    start = 1'b1;
    tick();
    acc_clr = 1'b0;
    start = 1'b0;
    chk("both lz", ev(0, 1, 0, 0, 0, 0, 0, 3'd0));
    tick();
    chk("both load", ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("both calc%0d", i), ev(0, 0, 0, 1, 0, 1, 0, 3'(i)));
    end
    tick();
    chk("both accum", ev(0, 0, 0, 0, 1, 1, 0, 3'd0));
    tick();
    chk("both done", ev(0, 0, 0, 0, 0, 0, 1, 3'd0));

    // Start re-pulsed in cycles 3 and 9 must be ignored
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rep load", ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    done_seen = 0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (done) done_seen++;
      if (c <= 9)       chk($sformatf("rep c%0d", c), ev(0, 0, 0, 1, 0, 1, 0, 3'(c - 2)));
      else if (c == 10) chk("rep accum", ev(0, 0, 0, 0, 1, 1, 0, 3'd0));
      else if (c == 11) chk("rep done", ev(0, 0, 0, 0, 0, 0, 1, 3'd0));
      else              chk($sformatf("rep idle c%0d", c), ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
      start = (c == 3 || c == 9);
    end
    start = 1'b0;
    checks++;
    assert (done_seen === 1) else begin
      errors++;
      $error("FAIL rep done count: observed=%0d expected=1", done_seen);
    end

    // CLR in cycle 5 of an operation aborts without write-back
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort load", ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("abort c%0d", c), ev(0, 0, 0, 1, 0, 1, 0, 3'(c - 2)));
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int c = 6; c <= 14; c++) begin
      chk($sformatf("abort idle c%0d", c), ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
      tick();
    end
    run_op("fresh", 8'b0110_0011);

    // Held start re-triggers every 12 cycles
    start = 1'b1;
    tick();
    chk("hold load1", ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    for (int c = 2; c <= 12; c++) tick();
    chk("hold idle", ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
    tick();
    chk("hold load2", ev(1, 0, 0, 0, 0, 1, 0, 3'd0));
    start = 1'b0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("hold abort", ev(0, 0, 0, 0, 0, 0, 0, 3'd0));

`ifdef MAC_OVF_DETECT_EN
    checks++;
    assert (acc_ovf === 1'b0) else begin
      errors++; $error("FAIL ovf init: observed=%b expected=0", acc_ovf);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    acc_carry = 1'b1;
    tick();
    acc_carry = 1'b0;
    checks++;
    assert (acc_ovf === 1'b1) else begin
      errors++; $error("FAIL ovf set: observed=%b expected=1", acc_ovf);
    end
    tick();
    run_op("ovf hold", 8'b0000_0001);
    checks++;
    assert (acc_ovf === 1'b1) else begin
      errors++; $error("FAIL ovf sticky: observed=%b expected=1", acc_ovf);
    end
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    tick();
    checks++;
    assert (acc_ovf === 1'b0) else begin
      errors++; $error("FAIL ovf clear: observed=%b expected=0", acc_ovf);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
